rr_mux4x1: RTL and testbench
============================

// Module: rr_mux4x1
// PURPOSE
// - Merges four independent valid/ready source channels into one output stream.
//   This is the collecting end of the 2x4 demux fan-out path: words that were
//   steered by sel are merged back into a single stream.
// - A round-robin arbiter picks one requesting channel at a time.
// - One registered output stage carries the data plus the 2-bit index of the
//   channel it came from, so a downstream demux can route it back.
// PARAMETERS
// - DATA_W   8   width of each channel's data word
// PORTS
// - clk        in   1         rising-edge clock
// - rst        in   1         synchronous reset, active-high
// - in_valid   in   4         per-channel valid; bit i = channel i
// - in_data    in   4*DATA_W  packed data; channel i at [i*DATA_W +: DATA_W]
// - in_ready   out  4         per-channel ready; at most one bit high (one-hot or zero)
// - out_valid  out  1         output word valid
// - out_data   out  DATA_W    output word
// - out_sel    out  2         source channel index of out_data
// - out_ready  in   1         downstream accepts when out_valid & out_ready
// BEHAVIOUR
// - Interface: one clock, clk. Reset rst is synchronous and active-high.
// - Reset (rst=1 at posedge):
//   - out_valid=0, out_data=0, out_sel=0.
//   - last-grant pointer ptr=3, so channel 0 has top priority first.
//   - Reset mid-transfer discards the held word; no channel is granted while rst=1.
// - Load condition: load = ~out_valid | out_ready. The output register can take a word.
// - Grant (combinational):
//   - If load and any in_valid is set, grant the first requesting channel, searching
//     ptr+1, ptr+2, ptr+3, ptr (mod 4).
//   - in_ready = grant (one-hot). in_ready is all zero when nothing is granted.
// - Transfer on channel i: in_valid[i] & in_ready[i] at a posedge. On that posedge:
//   - out_data <= in_data[i], out_sel <= i, out_valid <= 1, ptr <= i.
// - Latency: exactly 1 cycle from input handshake to out_valid.
// - Throughput: 1 word/cycle sustained while out_ready=1.
// - Stall: out_valid & ~out_ready.
//   - out_data, out_sel and out_valid are held stable; in_ready=0.
//   - ptr is unchanged.
// - Drain without refill: out_ready=1 and no in_valid -> out_valid <= 0 next cycle.
// - Simultaneous drain and refill in one cycle are legal: the old word leaves and the
//   new word loads with no bubble.
// - Fairness: with all four valid continuously, the grant order is 0,1,2,3,0,...
//   No channel waits more than 3 transfers.
// - Wrap-around: the ptr search is modulo 4, so ptr=3 searches 0,1,2,3.
// - in_valid may drop without a handshake. The arbiter re-evaluates every cycle and
//   must not latch a stale request.
// - Output signals are registered only; there is no combinational path from in_* to out_*.
// STRUCTURE
// - Shared package mux_pkg:
//   - localparam NUM_CH = 4, SEL_W = 2.
//   - function rr_pick(req[3:0], ptr[1:0]) returning a one-hot grant.
// - Sub-module rr_arbiter4:
//   - ports: req[3:0], ptr[1:0], en -> gnt[3:0], gnt_idx[1:0]; purely combinational.
// - Top level contains the output register, the ptr register and the data select.
// TESTING
// - Reset: assert rst with all in_valid=1 -> in_ready=0000, out_valid=0, out_data=0,
//   out_sel=0 on the next posedge.
// - Single channel: in_valid=0100, data2=8'hA5, out_ready=1.
//   -> in_ready=0100; next cycle out_valid=1, out_data=A5, out_sel=2.
// - Round-robin: all in_valid=1111, data_i=8'h10+i, out_ready=1 for 8 cycles.
//   -> out_sel sequence 0,1,2,3,0,1,2,3 with no bubbles.
// - Backpressure: hold out_ready=0 for 3 cycles with word 8'h11 (sel 1) held.
//   -> out_* stable, in_ready=0000 for all 3 cycles; releasing gives the next grant
//      to channel 2.
// - Wrap and skip: ptr=3, in_valid=1010.
//   -> grant channel 1, then channel 3, then channel 1.
// - Reset mid-stall: out_valid=1 with word 8'h33, pulse rst.
//   -> out_valid=0 and ptr=3; the first grant after reset goes to channel 0
//      when in_valid=1111.

Source files
------------

// File: rtl/rr_mux4x1_pkg.sv
// Shared definitions for the 4:1 round-robin merge path.
package mux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    // Round-robin pick: search ptr+1, ptr+2, ptr+3, ptr (mod 4) and return a
    // one-hot grant for the first requesting channel, or zero if none request.
    function automatic logic [NUM_CH-1:0] rr_pick(input logic [NUM_CH-1:0] req,
                                                  input logic [SEL_W-1:0]  ptr);
        logic [NUM_CH-1:0] g;
        logic [SEL_W-1:0]  idx;
        g = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = ptr + SEL_W'(k);
            if ((g == '0) && req[idx]) begin
                g[idx] = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin arbiter: one-hot grant plus its index.
module rr_arbiter4
    import mux_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    input  logic              en,
    output logic [NUM_CH-1:0] gnt,
    output logic [SEL_W-1:0]  gnt_idx
);

    // Grant is suppressed entirely when the output stage cannot accept a word.
    always_comb begin
        gnt = en ? rr_pick(req, ptr) : '0;
    end

    // Encode the one-hot grant; index is don't-care (zero) when nothing is granted.
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt[i]) begin
                gnt_idx = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/rr_mux4x1.sv
// Merges four valid/ready channels into one registered stream tagged with
// the source channel index, using a round-robin arbiter.
module rr_mux4x1
    import mux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_sel,
    input  logic                     out_ready
);

    logic [NUM_CH-1:0] gnt;
    logic [SEL_W-1:0]  gnt_idx;
    logic [SEL_W-1:0]  ptr;
    logic              load;
    logic [DATA_W-1:0] ch_data [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign ch_data[i] = in_data[i*DATA_W +: DATA_W];
    end

    // The output register can take a word when empty or being drained this cycle.
    assign load = ~out_valid | out_ready;

    // Nothing is granted during reset so no source believes its word was taken.
    rr_arbiter4 u_arb (
        .req     (in_valid),
        .ptr     (ptr),
        .en      (load & ~rst),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign in_ready = gnt;

    // Output stage and last-grant pointer; a grant implies a handshake because
    // grants are only issued to requesting channels.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= SEL_W'(NUM_CH - 1);
        end else if (|gnt) begin
            out_valid <= 1'b1;
            out_data  <= ch_data[gnt_idx];
            out_sel   <= gnt_idx;
            ptr       <= gnt_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_mux4x1.sv
// Directed bench for rr_mux4x1: stimulus pushes expected words into a
// scoreboard; a monitor pops and compares each word the DUT hands off.
module tb_rr_mux4x1;

    logic        clk;
    logic        rst;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_ready;
    logic [7:0]  d [4];

    int n_checks = 0;
    int n_fail   = 0;
    logic [9:0] sb [$];

    assign in_data = {d[3], d[2], d[1], d[0]};

    rr_mux4x1 #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after each rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] sel, input logic [7:0] data);
        sb.push_back({sel, data});
    endtask

    // Monitor: every accepted output word is compared against the scoreboard head.
    always @(negedge clk) begin
        logic [9:0] e;
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL out_word: got sel=%0d data=%0h expected no word at %0t",
                         out_sel, out_data, $time);
            end else begin
                e = sb.pop_front();
                if ({out_sel, out_data} !== e) begin
                    n_fail++;
                    $display("FAIL out_word: got sel=%0d data=%0h expected sel=%0d data=%0h at %0t",
                             out_sel, out_data, e[9:8], e[7:0], $time);
                end
            end
        end
    end

    initial begin
        logic [3:0] eg;
        for (int i = 0; i < 4; i++) d[i] = 8'h10 + 8'(i);

        // Reset with every channel requesting.
        rst = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        cyc();
        @(negedge clk);
        chk("rst_in_ready2", 32'(in_ready), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_sel", 32'(out_sel), 32'h0);

        // Round robin from ptr=3: 0,1,2,3,0,1,2,3 with no bubbles.
        for (int k = 0; k < 8; k++) begin
            cyc();
            rst = 1'b0;
            in_valid = 4'b1111;
            eg = 4'b0001 << (k % 4);
            @(negedge clk);
            chk("rr_in_ready", 32'(in_ready), 32'(eg));
            if (k > 0) chk("rr_no_bubble", 32'(out_valid), 32'h1);
            push(2'(k % 4), 8'h10 + 8'(k % 4));
        end
        cyc(); in_valid = 4'b0000;
        cyc();
        @(negedge clk);
        chk("drain_out_valid", 32'(out_valid), 32'h0);

        // Single channel 2 with A5.
        cyc(); in_valid = 4'b0100; d[2] = 8'hA5;
        @(negedge clk);
        chk("single_in_ready", 32'(in_ready), 32'h4);
        push(2'd2, 8'hA5);
        cyc(); in_valid = 4'b0000; d[2] = 8'h12;
        @(negedge clk);
        chk("single_out_valid", 32'(out_valid), 32'h1);
        cyc();

        // Backpressure: load word 11 from channel 1 (ptr=2), then stall 3 cycles.
        cyc(); in_valid = 4'b0010; d[1] = 8'h11;
        @(negedge clk);
        chk("bp_load_in_ready", 32'(in_ready), 32'h2);
        push(2'd1, 8'h11);
        for (int k = 0; k < 3; k++) begin
            cyc(); in_valid = 4'b1111; out_ready = 1'b0;
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'h0);
            chk("bp_out_valid", 32'(out_valid), 32'h1);
            chk("bp_out_data", 32'(out_data), 32'h11);
            chk("bp_out_sel", 32'(out_sel), 32'h1);
        end
        cyc(); out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", 32'(in_ready), 32'h4);
        push(2'd2, 8'h12);
        cyc(); in_valid = 4'b0000;
        cyc();

        // Move ptr to 3 via channel 3, then wrap and skip with 1010.
        cyc(); in_valid = 4'b1000;
        @(negedge clk);
        chk("wrap_pre_in_ready", 32'(in_ready), 32'h8);
        push(2'd3, 8'h13);
        for (int k = 0; k < 3; k++) begin
            cyc(); in_valid = 4'b1010;
            eg = (k == 1) ? 4'b1000 : 4'b0010;
            @(negedge clk);
            chk("wrap_in_ready", 32'(in_ready), 32'(eg));
            push((k == 1) ? 2'd3 : 2'd1, (k == 1) ? 8'h13 : 8'h11);
        end
        cyc(); in_valid = 4'b0000;
        cyc();

        // Reset mid-stall: word 33 from channel 2 (ptr=1) is held, then reset.
        cyc(); in_valid = 4'b0100; d[2] = 8'h33;
        @(negedge clk);
        chk("rs_load_in_ready", 32'(in_ready), 32'h4);
        cyc(); in_valid = 4'b0000; out_ready = 1'b0;
        @(negedge clk);
        chk("rs_held_valid", 32'(out_valid), 32'h1);
        chk("rs_held_data", 32'(out_data), 32'h33);
        cyc(); rst = 1'b1; in_valid = 4'b1111; d[2] = 8'h12;
        @(negedge clk);
        chk("rs_in_ready", 32'(in_ready), 32'h0);
        cyc(); rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("rs_out_valid", 32'(out_valid), 32'h0);
        chk("rs_out_data", 32'(out_data), 32'h0);
        chk("rs_first_grant", 32'(in_ready), 32'h1);
        push(2'd0, 8'h10);
        cyc(); in_valid = 4'b0000;
        cyc();
        cyc();
        @(negedge clk);
        chk("final_out_valid", 32'(out_valid), 32'h0);
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
